// File: rtl/mux4_rr_stream.sv
// 4-to-1 valid/ready stream mux with round-robin arbitration and one registered output stage.
// Define MUX_FIXED_PRIO_EN to use fixed priority (lane 0 highest) instead of round-robin.
module mux4_rr_stream #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_sel,
    input  logic           out_ready
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic [1:0]   out_sel_q,   out_sel_d;
    logic         load_en;
    logic         gnt_found;
    logic [1:0]   gnt_idx;
`ifndef MUX_FIXED_PRIO_EN
    logic [1:0]   last_q, last_d;
    logic [1:0]   cand;
`endif

    assign load_en = !out_valid_q || out_ready;

    // Scan in reverse search order so the first candidate in line overwrites the rest.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
`ifdef MUX_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = 2'(k);
            end
        end
`else
        cand = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
`endif
    end

    assign in_ready = (rst_n && load_en && gnt_found) ? (4'b0001 << gnt_idx) : 4'b0000;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifndef MUX_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        if (load_en) begin
            if (gnt_found) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data[gnt_idx*W +: W];
                out_sel_d   = gnt_idx;
`ifndef MUX_FIXED_PRIO_EN
                last_d      = gnt_idx;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Output stage: pointer resets to 3 so lane 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
`ifndef MUX_FIXED_PRIO_EN
            last_q      <= 2'd3;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifndef MUX_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4_rr_stream.sv
// Self-checking bench for mux4_rr_stream: directed scenarios plus a randomized run
// checked against a queue-free behavioural model of the arbitration rules.
module tb_mux4_rr_stream;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     in_valid = 4'b0000;
    logic [7:0]     lane_d [4];
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_valid;
    logic [7:0] m_data;
    int         m_sel;
    int         m_last;

    assign in_data = {lane_d[3], lane_d[2], lane_d[1], lane_d[0]};

    mux4_rr_stream #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] v, input int last);
`ifdef MUX_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= 4; k++) begin
            int l;
            l = (last + k) % 4;
            if (v[l]) return l;
        end
`endif
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = pick(in_valid, m_last);
        if ((!m_valid || out_ready) && g >= 0) return 4'(1 << g);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 0;
        m_last  = 3;
    endtask

    task automatic model_advance();
        int g;
        if (!m_valid || out_ready) begin
            g = pick(in_valid, m_last);
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = lane_d[g];
                m_sel   = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic test_reset();
        in_valid = 4'b1111;
        for (int k = 0; k < 4; k++) lane_d[k] = 8'h50 + 8'(k);
        out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel: got %0d expected 0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready); end
        @(posedge clk);
        model_advance();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_valid: got %b expected 1", out_valid); end
        // Mid-stream asynchronous reset with a beat pending
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL midreset_out_data: got %h expected 00", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL midreset_out_sel: got %0d expected 0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL midreset_in_ready: got %b expected 0000", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL midreset_restart: got %b expected 0001", in_ready); end
    endtask

    task automatic test_single_lane();
        do_reset();
        lane_d[2] = 8'hA5;
        in_valid = 4'b0100;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready c%0d: got %b expected 0100", c, in_ready); end
            if (c >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hA5) begin
                    errors++; $display("FAIL single_out c%0d: got v=%b sel=%0d data=%h expected v=1 sel=2 data=a5", c, out_valid, out_sel, out_data);
                end
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    task automatic test_round_robin();
        int es;
        do_reset();
        for (int k = 0; k < 4; k++) lane_d[k] = 8'h10 + 8'(k);
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
`ifdef MUX_FIXED_PRIO_EN
            es = 0;
            checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rr_in_ready c%0d: got %b expected 0001", c, in_ready); end
`else
            es = (c - 1) % 4;
            checks++; if (in_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_in_ready c%0d: got %b expected %b", c, in_ready, 4'(1 << (c % 4))); end
`endif
            if (c >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_sel !== 2'(es) || out_data !== 8'h10 + 8'(es)) begin
                    errors++; $display("FAIL rr_out c%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h", c, out_valid, out_sel, out_data, es, 8'h10 + 8'(es));
                end
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    task automatic test_backpressure();
        int es;
        do_reset();
        for (int k = 0; k < 4; k++) lane_d[k] = 8'h10 + 8'(k);
        in_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            out_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
`ifdef MUX_FIXED_PRIO_EN
            es = 0;
`else
            es = (c <= 6) ? 2 : (c - 4) % 4;
`endif
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_sel !== 2'(es) || out_data !== 8'h10 + 8'(es)) begin
                    errors++; $display("FAIL bp_out c%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h", c, out_valid, out_sel, out_data, es, 8'h10 + 8'(es));
                end
            end
            if (c >= 3 && c <= 5) begin
                checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready c%0d: got %b expected 0000", c, in_ready); end
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    task automatic test_gaps();
        logic [3:0] vseq [7];
        vseq = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
        do_reset();
        for (int k = 0; k < 4; k++) lane_d[k] = 8'h30 + 8'(k);
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = vseq[c];
            @(negedge clk);
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL gap_in_ready c%0d: got %b expected %b", c, in_ready, exp_ready()); end
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL gap_out_valid c%0d: got %b expected %b", c, out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (out_sel !== 2'(m_sel) || out_data !== m_data) begin errors++; $display("FAIL gap_out c%0d: got sel=%0d data=%h expected sel=%0d data=%h", c, out_sel, out_data, m_sel, m_data); end
            end
`ifndef MUX_FIXED_PRIO_EN
            if (c == 1) begin checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL gap_sel1: got %0d expected 1", out_sel); end end
            if (c == 2) begin checks++; if (out_sel !== 2'd3) begin errors++; $display("FAIL gap_sel3: got %0d expected 3", out_sel); end end
`endif
            if (c == 3) begin checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_idle: got %b expected 0", out_valid); end end
            if (c == 4) begin checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL gap_lane0_first: got %b expected 0001", in_ready); end end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    task automatic test_random();
        logic [3:0] er;
        do_reset();
        er = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (!(in_valid[k] && !er[k]) || c == 0) begin
                    in_valid[k] = ($urandom_range(0, 99) < 55);
                    lane_d[k] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            er = exp_ready();
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rand_in_ready c%0d: got %b expected %b", c, in_ready, er); end
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_out_valid c%0d: got %b expected %b", c, out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (out_sel !== 2'(m_sel)) begin errors++; $display("FAIL rand_out_sel c%0d: got %0d expected %0d", c, out_sel, m_sel); end
                checks++; if (out_data !== m_data) begin errors++; $display("FAIL rand_out_data c%0d: got %h expected %h", c, out_data, m_data); end
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_gaps();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_stream.md
Name: mux4_rr_stream

Overview:
- 4-to-1 stream multiplexer; the transmit-side counterpart of the 1-to-4 demux.
- Merges four independent valid/ready lanes onto one output.
- Tags each output beat with a 2-bit select code, so a downstream demux can route it back to lane `out_sel`.
- Round-robin arbitration between lanes; one registered output stage.

Parameters:
- W, 8, data width of each lane and of the output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  4  per-lane valid; bit k belongs to lane k
- in_data  input  4*W  lane k occupies bits [k*W+W-1 : k*W]
- in_ready  output  4  per-lane ready; at most one bit is high in any cycle
- out_valid  output  1  output beat present
- out_data  output  W  data of the output beat
- out_sel  output  2  source lane index of the output beat
- out_ready  input  1  downstream accepts the beat

Interface:
- One clock, `clk`.
- Reset `rst_n` is asynchronous and active-low.

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0.
  - Grant pointer last=3, so lane 0 is first in line after reset.
  - in_ready=0 while `rst_n` is low.
- Load condition: load_en = !out_valid || out_ready.
- Arbitration (combinational, evaluated only when load_en=1):
  - Search lanes in order last+1, last+2, last+3, last (mod 4); pick the first with in_valid=1.
  - in_ready[g]=1 only for the granted lane g; all other in_ready bits are 0.
  - When load_en=0, in_ready=0000.
- Transfer on an input lane occurs when in_valid[k] && in_ready[k] at a rising clk edge. On that edge:
  - out_data <= lane g data.
  - out_sel <= g.
  - out_valid <= 1.
  - last <= g.
- Latency: an accepted input beat appears on the output the next cycle.
- Throughput: 1 beat per cycle while out_ready=1.
- Empty load: if load_en=1 and no lane is valid, out_valid <= 0 on the edge. out_data/out_sel keep their old values and last is unchanged.
- Hold: while out_valid=1 && out_ready=0, out_data and out_sel are stable and no input is accepted.
- Simultaneous drain and refill: when out_ready=1 and a lane is valid in the same cycle, the old beat leaves and the new beat is loaded on the same edge, with no bubble.
- Fairness: with all four lanes continuously valid and out_ready=1, out_sel follows 0,1,2,3,0,…
- A single valid lane receives every slot; a lane never waits more than 3 grants.
- Input protocol: a lane must hold in_valid and in_data until it is accepted. The block does not check this.
- Reset mid-operation: any pending output beat is discarded. After reset release, arbitration restarts at lane 0.
- Wrap-around: pointer arithmetic is 2-bit modulo 4 (last=3 → search starts at 0).

Optional Feature:
- Macro: MUX_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority (lane 0 > 1 > 2 > 3) and the last pointer is not used. Lane 3 may starve.
- Not defined: round-robin as specified above.
- All other behaviour (latency, hold, reset) is identical in both builds.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with out_valid=1. Required: out_valid=0, out_sel=0, out_data=0 immediately, without waiting for a clk edge; in_ready=0000.
- Single lane: in_valid=0100, in_data lane 2=8'hA5, out_ready=1. Required: next cycle out_valid=1, out_sel=2, out_data=8'hA5; in_ready=0100 every cycle.
- Round-robin: in_valid=1111 held, lanes carrying 8'h10,8'h11,8'h12,8'h13, out_ready=1. Required: out_sel sequence 0,1,2,3,0,1 with matching data, no idle cycles.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1111. Required: out_data/out_sel frozen and in_ready=0000. On release, out_sel advances by 1 per cycle.
- Gaps: in_valid=1010 then 0000 for 2 cycles, out_ready=1. Required: out_sel 1,3, then out_valid=0. Next request on lane 0 is granted before lane 1 (pointer=3).
- MUX_FIXED_PRIO_EN build: in_valid=1111 held. Required: out_sel=0 on every beat.
